// File: rtl/id_decode_fwd.sv
// MIPS-subset instruction decode stage: register file, operand forwarding,
// load-use hazard stall, branch/jump redirect and a registered ID/EX output.
module id_decode_fwd #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int CNTW = 16,
  localparam int RAW = (NREG > 1) ? $clog2(NREG) : 1
) (
  input  logic            clk,
  input  logic            rst,
  // fetch side
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc4,
  input  logic [31:0]     in_instr,
  // register-file write port
  input  logic            wb_we,
  input  logic [RAW-1:0]  wb_addr,
  input  logic [XLEN-1:0] wb_data,
  // forwarding sources
  input  logic            ex_we,
  input  logic            ex_load,
  input  logic [RAW-1:0]  ex_addr,
  input  logic [XLEN-1:0] ex_data,
  input  logic            mem_we,
  input  logic [RAW-1:0]  mem_addr,
  input  logic [XLEN-1:0] mem_data,
  input  logic            flush,
  // control-flow redirect
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  // ID/EX stage
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_rs,
  output logic [XLEN-1:0] out_rt,
  output logic [XLEN-1:0] out_imm,
  output logic [RAW-1:0]  out_waddr,
  output logic            out_reg_we,
  output logic            out_mem_we,
  output logic            out_mem_to_reg,
  output logic            out_alu_imm,
  output logic [CNTW-1:0] stall_cnt
);

  // Handshake: a transfer happens on a rising edge where valid && ready are
  // both high; valid never depends on ready, and an offered payload holds
  // until taken. flush overrides both sides for the cycle it is asserted.

  typedef struct packed {
    logic [XLEN-1:0] rs;
    logic [XLEN-1:0] rt;
    logic [XLEN-1:0] imm;
    logic [RAW-1:0]  waddr;
    logic            reg_we;
    logic            mem_we;
    logic            mem_to_reg;
    logic            alu_imm;
  } idex_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FN_JR    = 6'h08;

  // ---------------------------------------------------------------------
  // Field extraction
  // ---------------------------------------------------------------------
  logic [5:0]     op;
  logic [5:0]     funct;
  logic [15:0]    imm16;
  logic [RAW-1:0] rs_a;
  logic [RAW-1:0] rt_a;
  logic [RAW-1:0] rd_a;
  logic           unused_instr;

  assign op     = in_instr[31:26];
  assign funct  = in_instr[5:0];
  assign imm16  = in_instr[15:0];
  assign rs_a   = in_instr[21 +: RAW];
  assign rt_a   = in_instr[16 +: RAW];
  assign rd_a   = in_instr[11 +: RAW];
  assign unused_instr = ^in_instr;

  // ---------------------------------------------------------------------
  // Instruction class decode
  // ---------------------------------------------------------------------
  logic is_rtype, is_jr, is_addi, is_andi, is_ori, is_lw, is_sw;
  logic is_beq, is_bne, is_j, is_jal;
  logic dec_reg_we, dec_mem_we, dec_mem_to_reg, dec_alu_imm;
  logic reads_rs, reads_rt;
  logic [RAW-1:0]  dec_waddr;
  logic [XLEN-1:0] imm_sext;
  logic [XLEN-1:0] dec_imm;

  always_comb begin
    is_rtype = (op == OP_RTYPE) && (funct != FN_JR);
    is_jr    = (op == OP_RTYPE) && (funct == FN_JR);
    is_addi  = (op == OP_ADDI);
    is_andi  = (op == OP_ANDI);
    is_ori   = (op == OP_ORI);
    is_lw    = (op == OP_LW);
    is_sw    = (op == OP_SW);
    is_beq   = (op == OP_BEQ);
    is_bne   = (op == OP_BNE);
    is_j     = (op == OP_J);
    is_jal   = (op == OP_JAL);
  end

  always_comb begin
    dec_reg_we     = is_rtype | is_addi | is_andi | is_ori | is_lw | is_jal;
    dec_mem_we     = is_sw;
    dec_mem_to_reg = is_lw;
    dec_alu_imm    = is_addi | is_andi | is_ori | is_lw | is_sw;
    reads_rs       = !(is_j | is_jal);
    reads_rt       = is_rtype | is_sw | is_beq | is_bne;
    if (op == OP_RTYPE) begin
      dec_waddr = rd_a;
    end else if (is_jal) begin
      dec_waddr = RAW'(NREG - 1);
    end else begin
      dec_waddr = rt_a;
    end
    imm_sext = {{(XLEN-16){imm16[15]}}, imm16};
    if (is_andi | is_ori) begin
      dec_imm = {{(XLEN-16){1'b0}}, imm16};
    end else begin
      dec_imm = imm_sext;
    end
  end

  // ---------------------------------------------------------------------
  // Register file (write-through handled by the WB forwarding leg)
  // ---------------------------------------------------------------------
  logic [XLEN-1:0] rf_q [NREG];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) begin
        rf_q[i] <= '0;
      end
    end else if (wb_we && (wb_addr != '0)) begin
      rf_q[wb_addr] <= wb_data;
    end
  end

  function automatic logic [XLEN-1:0] fwd_sel(
    input logic [RAW-1:0]  a,
    input logic [XLEN-1:0] rf_val,
    input logic            e_we,
    input logic            e_load,
    input logic [RAW-1:0]  e_addr,
    input logic [XLEN-1:0] e_data,
    input logic            m_we,
    input logic [RAW-1:0]  m_addr,
    input logic [XLEN-1:0] m_data,
    input logic            w_we,
    input logic [RAW-1:0]  w_addr,
    input logic [XLEN-1:0] w_data
  );
    logic [XLEN-1:0] v;
    if (a == '0)                             v = '0;
    else if (e_we && !e_load && e_addr == a) v = e_data;
    else if (m_we && m_addr == a)            v = m_data;
    else if (w_we && w_addr == a)            v = w_data;
    else                                     v = rf_val;
    return v;
  endfunction

  logic [XLEN-1:0] rs_val;
  logic [XLEN-1:0] rt_val;

  always_comb begin
    rs_val = fwd_sel(rs_a, rf_q[rs_a], ex_we, ex_load, ex_addr, ex_data,
                     mem_we, mem_addr, mem_data, wb_we, wb_addr, wb_data);
    rt_val = fwd_sel(rt_a, rf_q[rt_a], ex_we, ex_load, ex_addr, ex_data,
                     mem_we, mem_addr, mem_data, wb_we, wb_addr, wb_data);
  end

  // ---------------------------------------------------------------------
  // Hazard, handshake and redirect
  // ---------------------------------------------------------------------
  idex_t out_q, out_d;
  logic  out_valid_q, out_valid_d;
  logic  hazard;
  logic  accept;
  logic  taken;
  logic [XLEN-1:0] br_target;
  logic [XLEN-1:0] j_target;

  // A load in EX cannot forward yet, so any reader of its target must wait.
  assign hazard = ex_we && ex_load && (ex_addr != '0) &&
                  ((reads_rs && (ex_addr == rs_a)) ||
                   (reads_rt && (ex_addr == rt_a)));

  assign in_ready = rst && !flush && !hazard && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    taken     = (is_beq && (rs_val == rt_val)) ||
                (is_bne && (rs_val != rt_val)) ||
                is_j || is_jal || is_jr;
    br_target = in_pc4 + {imm_sext[XLEN-3:0], 2'b00};
    j_target  = {in_pc4[XLEN-1:28], in_instr[25:0], 2'b00};
    if (is_jr) begin
      redirect_pc = rs_val;
    end else if (is_j || is_jal) begin
      redirect_pc = j_target;
    end else begin
      redirect_pc = br_target;
    end
  end

  assign redirect_valid = accept && taken;

  // ---------------------------------------------------------------------
  // ID/EX output register
  // ---------------------------------------------------------------------
  always_comb begin
    out_d       = out_q;
    out_valid_d = out_valid_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_valid_d      = 1'b1;
      out_d.rs         = is_jal ? in_pc4 : rs_val;
      out_d.rt         = is_jal ? '0 : rt_val;
      out_d.imm        = dec_imm;
      out_d.waddr      = dec_waddr;
      out_d.reg_we     = dec_reg_we;
      out_d.mem_we     = dec_mem_we;
      out_d.mem_to_reg = dec_mem_to_reg;
      out_d.alu_imm    = dec_alu_imm;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  // ---------------------------------------------------------------------
  // Load-use stall counter (saturating)
  // ---------------------------------------------------------------------
  logic [CNTW-1:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (in_valid && hazard && !flush && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign out_valid      = out_valid_q;
  assign out_rs         = out_q.rs;
  assign out_rt         = out_q.rt;
  assign out_imm        = out_q.imm;
  assign out_waddr      = out_q.waddr;
  assign out_reg_we     = out_q.reg_we;
  assign out_mem_we     = out_q.mem_we;
  assign out_mem_to_reg = out_q.mem_to_reg;
  assign out_alu_imm    = out_q.alu_imm;
  assign stall_cnt      = stall_cnt_q;

endmodule

// File: doc/id_decode_fwd.md
ID_DECODE_FWD -- requirements
Module: id_decode_fwd

Interface
REQ-001 SHALL have parameter XLEN, 32, datapath width (>=32).
REQ-002 SHALL have parameter NREG, 32, architectural register count (power of 2, 2..32); RAW = log2(NREG).
REQ-003 SHALL have parameter CNTW, 16, stall-counter width.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-006 SHALL have ports in_valid input 1, in_ready output 1, in_pc4 input XLEN, in_instr input 32: fetch-side handshake, PC+4 and MIPS instruction.
REQ-007 SHALL have ports wb_we input 1, wb_addr input RAW, wb_data input XLEN: register-file write.
REQ-008 SHALL have ports ex_we input 1, ex_load input 1, ex_addr input RAW, ex_data input XLEN; mem_we input 1, mem_addr input RAW, mem_data input XLEN: forwarding sources.
REQ-009 SHALL have port flush input 1: discard held and incoming instruction.
REQ-010 SHALL have ports redirect_valid output 1, redirect_pc output XLEN: taken branch/jump target.
REQ-011 SHALL have ports out_valid output 1, out_ready input 1, out_rs output XLEN, out_rt output XLEN, out_imm output XLEN, out_waddr output RAW, out_reg_we, out_mem_we, out_mem_to_reg, out_alu_imm output 1 each: registered ID/EX stage.
REQ-012 SHALL have port stall_cnt output CNTW: cycles lost to load-use stalls.

Function
REQ-013 SHALL decode: R-type (op 0), addi 08, andi 0C, ori 0D, lw 23, sw 2B, beq 04, bne 05, j 02, jal 03, jr (op 0, funct 08); other opcodes are NOPs (all write/enable flags 0).
REQ-014 out_imm SHALL be zero-extended imm16 for andi/ori, sign-extended to XLEN otherwise.
REQ-015 out_waddr SHALL be rd for R-type, rt for I-type, NREG-1 for jal; for NREG<32 register fields SHALL be truncated to RAW bits.
REQ-016 jal SHALL present out_rs = in_pc4, out_rt = 0, out_reg_we = 1.
REQ-017 Register file: NREG x XLEN, written on clk edge when wb_we && wb_addr != 0; register 0 SHALL read 0.
REQ-018 Operand value priority: addr 0 -> 0; EX match (ex_we, !ex_load) -> ex_data; MEM match -> mem_data; WB match (wb_we) -> wb_data; else register file.
REQ-019 hazard SHALL be 1 when ex_we && ex_load && ex_addr != 0 && ex_addr equals a source register the instruction reads (rs for all but j/jal; rt for R-type, sw, beq, bne).
REQ-020 in_ready SHALL equal !flush && !hazard && (!out_valid || out_ready).
REQ-021 Acceptance = in_valid && in_ready; on acceptance the output stage SHALL load decoded fields on the next edge, out_valid <= 1.
REQ-022 When out_valid && out_ready and no acceptance, out_valid SHALL drop to 0 (bubble); when !out_ready, all out_* SHALL hold.
REQ-023 redirect_valid SHALL be combinational, high only on acceptance of: beq with rs==rt, bne with rs!=rt, j, jal, jr (forwarded values).
REQ-024 redirect_pc: branch = in_pc4 + (sext(imm16)<<2); j/jal = {in_pc4[XLEN-1:28], instr[25:0], 00}; jr = forwarded rs.
REQ-025 flush SHALL clear out_valid on the next edge, block acceptance and redirect that cycle, and override out_ready.
REQ-026 stall_cnt SHALL increment by 1 each cycle with in_valid && hazard && !flush, saturating at all-ones.
REQ-027 WB write and read of same register in one cycle SHALL return wb_data (write-through).

Reset
REQ-028 rst low SHALL immediately clear out_valid, all out_* data/flags, stall_cnt and every register-file entry to 0, independent of clk.
REQ-029 redirect_valid SHALL be 0 while rst is low; in_ready SHALL be 0 while rst is low.
REQ-030 Reset released mid-transaction SHALL leave no accepted instruction; first acceptance occurs on the first edge after rst high.

Verification
REQ-031 wb write r5=0x1234, then addi r6,r5,1 with out_ready=1 -> next cycle out_valid=1, out_rs=0x1234, out_imm=1, out_waddr=6, out_reg_we=1.
REQ-032 ex_we=1, ex_load=1, ex_addr=5, in_instr add r7,r5,r0 -> in_ready=0, stall_cnt +1 per cycle, out_valid falls to 0 after one out handshake; ex_load=0 -> accepted.
REQ-033 ex_addr=mem_addr=3, ex_data=0xA, mem_data=0xB, beq r3,r0,+4 -> out_rs=0xA, redirect_valid=0 (0xA != 0); with ex_we=0 rs=0xB, same result.
REQ-034 jal target 0x100, in_pc4=0x40 -> redirect_valid=1, redirect_pc=0x400, next out_rs=0x40, out_waddr=31.
REQ-035 out_ready=0 for 3 cycles with out_valid=1 -> in_ready=0, out_* stable; flush in cycle 2 -> out_valid=0 next edge.
REQ-036 rst low asynchronously mid-stream -> out_valid=0, stall_cnt=0 before next clk edge; register reads return 0 after release.
